pc_sequencer: RTL and testbench

Program-counter sequencer for the processor fetch stage. It holds the PC and builds the four packed next-PC candidates and the 2-bit select that drive the shared `mux4x1`. It registers the mux output back as the new PC, so it sits both upstream of the mux (`inputVal`, `sel`) and downstream of it (`y`). It also owns a two-state interrupt FSM with a single saved return address.

---
 rtl/pc_sequencer.sv | 117 +++++++++++
 tb/tb_pc_sequencer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-stage program-counter sequencer.
// Builds four next-PC candidates and a 2-bit select for an external mux4x1.
// Registers the mux output back as the PC. Also runs a RUN/ISR interrupt FSM
// that saves a single return address.
// Ports:
//   clk, rst           : clock, async active-high reset
//   stall              : freeze PC, FSM state and savedPc
//   branchTaken/Offset : PC-relative branch (offset relative to PC+1)
//   jump/jumpTarget    : absolute jump
//   irq, reti          : level interrupt request, return from interrupt
//   pcCandidates       : {slot3, slot2, slot1, slot0} to mux inputVal
//   pcSel              : mux select (combinational)
//   pcNext             : mux output y
//   pc, savedPc        : registered PC and return address
//   inIsr, irqAck      : in-ISR flag, one-cycle interrupt-entry pulse
module pc_sequencer #(
  parameter int unsigned     size         = 8,
  parameter logic [size-1:0] RESET_VECTOR = '0,
  parameter logic [size-1:0] IRQ_VECTOR   = size'(8'hF0)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              branchTaken,
  input  logic [size-1:0]   branchOffset,
  input  logic              jump,
  input  logic [size-1:0]   jumpTarget,
  input  logic              irq,
  input  logic              reti,
  output logic [size*4-1:0] pcCandidates,
  output logic [1:0]        pcSel,
  input  logic [size-1:0]   pcNext,
  output logic [size-1:0]   pc,
  output logic [size-1:0]   savedPc,
  output logic              inIsr,
  output logic              irqAck
);

  typedef enum logic {
    RUN = 1'b0,
    ISR = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [size-1:0] pc_q, pc_d;
  logic [size-1:0] saved_q, saved_d;
  logic            ack_q, ack_d;

  logic [size-1:0] pc_inc;
  logic [size-1:0] slot3;
  logic            take_irq;
  logic            take_reti;

  // Candidate slots; all arithmetic wraps modulo 2^size.
  assign pc_inc       = pc_q + size'(1);
  assign slot3        = (state_q == ISR) ? saved_q : IRQ_VECTOR;
  assign pcCandidates = {slot3, jumpTarget, pc_inc + branchOffset, pc_inc};

  // Priority select; nothing is accepted during reset or stall.
  always_comb begin
    pcSel     = 2'b00;
    take_irq  = 1'b0;
    take_reti = 1'b0;
    if (!rst && !stall) begin
      if (state_q == RUN && irq) begin
        pcSel    = 2'b11;
        take_irq = 1'b1;
      end else if (state_q == ISR && reti) begin
        pcSel     = 2'b11;
        take_reti = 1'b1;
      end else if (jump) begin
        pcSel = 2'b10;
      end else if (branchTaken) begin
        pcSel = 2'b01;
      end
    end
  end

  // Next-state values; a stall holds everything and drops irqAck.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    saved_d = saved_q;
    ack_d   = 1'b0;
    if (!stall) begin
      pc_d = pcNext;
      if (take_irq) begin
        state_d = ISR;
        saved_d = pc_q;
        ack_d   = 1'b1;
      end else if (take_reti) begin
        state_d = RUN;
      end
    end
  end

  // FSM and PC registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      pc_q    <= RESET_VECTOR;
      saved_q <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      saved_q <= saved_d;
      ack_q   <= ack_d;
    end
  end

  assign pc      = pc_q;
  assign savedPc = saved_q;
  assign inIsr   = (state_q == ISR);
  assign irqAck  = ack_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer with a behavioural mux4x1 closing the PC loop.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst, stall, branchTaken, jump, irq, reti;
  logic [7:0]  branchOffset, jumpTarget, pcNext, pc, savedPc;
  logic [31:0] pcCandidates;
  logic [1:0]  pcSel;
  logic        inIsr, irqAck;

  int checks = 0;
  int errors = 0;

  // Reference state, kept as plain integers
  int m_pc, m_saved;
  bit m_isr, m_ack;

  typedef struct {
    logic       stall;
    logic       br;
    logic [7:0] off;
    logic       jmp;
    logic [7:0] tgt;
    logic       irq;
    logic       reti;
    logic [1:0] sel;
    logic [7:0] pc;
    logic [7:0] saved;
    logic       isr;
    logic       ack;
  } vec_t;

  vec_t tbl[$];

  pc_sequencer #(.size(8), .RESET_VECTOR(8'h00), .IRQ_VECTOR(8'hF0)) dut (
    .clk(clk), .rst(rst), .stall(stall), .branchTaken(branchTaken),
    .branchOffset(branchOffset), .jump(jump), .jumpTarget(jumpTarget),
    .irq(irq), .reti(reti), .pcCandidates(pcCandidates), .pcSel(pcSel),
    .pcNext(pcNext), .pc(pc), .savedPc(savedPc), .inIsr(inIsr), .irqAck(irqAck)
  );

  // mux4x1 stand-in
  always_comb begin
    case (pcSel)
      2'd0:    pcNext = pcCandidates[7:0];
      2'd1:    pcNext = pcCandidates[15:8];
      2'd2:    pcNext = pcCandidates[23:16];
      default: pcNext = pcCandidates[31:24];
    endcase
  end

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int exp_sel();
    if (stall) return 0;
    if (!m_isr && irq) return 3;
    if (m_isr && reti) return 3;
    if (jump) return 2;
    if (branchTaken) return 1;
    return 0;
  endfunction

  // Target the PC should land on after this edge
  function automatic int exp_next_pc();
    if (stall) return m_pc;
    if (!m_isr && irq) return 'hF0;
    if (m_isr && reti) return m_saved;
    if (jump) return int'(jumpTarget);
    if (branchTaken) return (m_pc + 1 + int'(branchOffset)) % 256;
    return (m_pc + 1) % 256;
  endfunction

  task automatic model_reset();
    m_pc = 0; m_saved = 0; m_isr = 0; m_ack = 0;
  endtask

  task automatic check_regs(input string tag);
    chk({tag, ".pc"}, 32'(pc), 32'(m_pc));
    chk({tag, ".savedPc"}, 32'(savedPc), 32'(m_saved));
    chk({tag, ".inIsr"}, 32'(inIsr), 32'(m_isr));
    chk({tag, ".irqAck"}, 32'(irqAck), 32'(m_ack));
  endtask

  // One clock: check combinational outputs, take the edge, check registers.
  task automatic do_cycle(input string tag);
    int np;
    #1;
    chk({tag, ".pcSel"}, 32'(pcSel), 32'(exp_sel()));
    chk({tag, ".slot0"}, 32'(pcCandidates[7:0]), 32'((m_pc + 1) % 256));
    chk({tag, ".slot1"}, 32'(pcCandidates[15:8]), 32'((m_pc + 1 + int'(branchOffset)) % 256));
    chk({tag, ".slot2"}, 32'(pcCandidates[23:16]), 32'(jumpTarget));
    chk({tag, ".slot3"}, 32'(pcCandidates[31:24]), 32'(m_isr ? m_saved : 'hF0));
    np = exp_next_pc();
    @(posedge clk);
    if (!stall) begin
      if (!m_isr && irq) begin
        m_saved = m_pc; m_isr = 1; m_ack = 1;
      end else begin
        m_ack = 0;
        if (m_isr && reti) m_isr = 0;
      end
      m_pc = np;
    end else begin
      m_ack = 0;
    end
    #1;
    check_regs(tag);
  endtask

  task automatic idle_inputs();
    stall = 0; branchTaken = 0; branchOffset = 0; jump = 0; jumpTarget = 0;
    irq = 0; reti = 0;
  endtask

  task automatic run_row(input int idx);
    string tag;
    vec_t v;
    v = tbl[idx];
    tag = $sformatf("row%0d", idx);
    stall = v.stall; branchTaken = v.br; branchOffset = v.off;
    jump = v.jmp; jumpTarget = v.tgt; irq = v.irq; reti = v.reti;
    #1;
    chk({tag, ".tbl_sel"}, 32'(pcSel), 32'(v.sel));
    do_cycle(tag);
    chk({tag, ".tbl_pc"}, 32'(pc), 32'(v.pc));
    chk({tag, ".tbl_saved"}, 32'(savedPc), 32'(v.saved));
    chk({tag, ".tbl_isr"}, 32'(inIsr), 32'(v.isr));
    chk({tag, ".tbl_ack"}, 32'(irqAck), 32'(v.ack));
  endtask

  // Async reset pulse in mid-cycle, checked before the next edge.
  task automatic reset_pulse(input string tag);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_regs(tag);
    chk({tag, ".pcSel"}, 32'(pcSel), 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    // stall br off jmp tgt irq reti | sel pc saved isr ack
    tbl.push_back('{1'b0, 1'b0, 8'h00, 1'b1, 8'h10, 1'b0, 1'b0, 2'd2, 8'h10, 8'h00, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 8'hFE, 1'b0, 8'h00, 1'b0, 1'b0, 2'd1, 8'h0F, 8'h00, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 8'h00, 1'b1, 8'h40, 1'b0, 1'b0, 2'd2, 8'h40, 8'h00, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 8'h00, 1'b1, 8'hFF, 1'b0, 1'b0, 2'd2, 8'hFF, 8'h00, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 8'h00, 8'h00, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 8'h00, 1'b1, 8'hFE, 1'b0, 1'b0, 2'd2, 8'hFE, 8'h00, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 8'h05, 1'b0, 8'h00, 1'b0, 1'b0, 2'd1, 8'h04, 8'h00, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 8'h00, 1'b1, 8'h02, 1'b0, 1'b0, 2'd2, 8'h02, 8'h00, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 8'hF0, 1'b0, 8'h00, 1'b0, 1'b0, 2'd1, 8'hF3, 8'h00, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 8'h00, 1'b1, 8'h20, 1'b0, 1'b0, 2'd2, 8'h20, 8'h00, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 8'h00, 1'b1, 8'h40, 1'b1, 1'b0, 2'd3, 8'hF0, 8'h20, 1'b1, 1'b1});
    tbl.push_back('{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 2'd0, 8'hF1, 8'h20, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 2'd0, 8'hF2, 8'h20, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 2'd3, 8'h20, 8'h20, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 8'h00, 1'b1, 8'h30, 1'b0, 1'b0, 2'd2, 8'h30, 8'h20, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 2'd0, 8'h30, 8'h20, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 2'd0, 8'h30, 8'h20, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 2'd0, 8'h30, 8'h20, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 2'd3, 8'hF0, 8'h30, 1'b1, 1'b1});
    tbl.push_back('{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 2'd3, 8'h30, 8'h30, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 8'h00, 1'b1, 8'h05, 1'b0, 1'b0, 2'd2, 8'h05, 8'h30, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 2'd0, 8'h06, 8'h30, 1'b0, 1'b0});

    idle_inputs();
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    check_regs("reset");
    chk("reset.pcSel", 32'(pcSel), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed vectors
    for (int i = 0; i < tbl.size(); i++) run_row(i);

    // Reset inside ISR, with irq still held
    idle_inputs();
    irq = 1'b1;
    do_cycle("isr_enter");
    chk("isr_enter.inIsr_set", 32'(inIsr), 32'd1);
    reset_pulse("rst_in_isr");
    chk("rst_in_isr.savedPc", 32'(savedPc), 32'h00);
    idle_inputs();

    // Reset mid-run at pc=37, then sequential run
    jump = 1'b1; jumpTarget = 8'h37;
    do_cycle("to37");
    chk("to37.pc", 32'(pc), 32'h37);
    idle_inputs();
    reset_pulse("rst_mid_run");
    chk("rst_mid_run.pc", 32'(pc), 32'h00);
    for (int i = 1; i <= 3; i++) begin
      do_cycle("seq");
      chk("seq.pc", 32'(pc), 32'(i));
    end

    // Randomised run against the reference model
    for (int i = 0; i < 400; i++) begin
      stall        = ($urandom_range(0, 4) == 0);
      branchTaken  = ($urandom_range(0, 2) == 0);
      branchOffset = 8'($urandom);
      jump         = ($urandom_range(0, 4) == 0);
      jumpTarget   = 8'($urandom);
      irq          = ($urandom_range(0, 5) == 0);
      reti         = ($urandom_range(0, 4) == 0);
      do_cycle("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard stop in case the run stalls
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got running, expected finished");
    $fatal(1);
  end

endmodule
